stepper_move_sequencer: RTL and testbench
=========================================

Name: stepper_move_sequencer

Overview:
- Move controller for the bipolar NEMA 17 / A4988 stepper path. Replaces the free-running STEP divisor with a counted, accelerated move.
- Accepts a move command (step count, direction, step mode) and drives the STEP, DIR and MS1..MS3 pins with A4988-safe timing.
- Applies a trapezoidal speed ramp, reports progress, and pulses done at the end of each move.

Parameters:
- PULSE_HIGH_CYC, 100, STEP high time in clk cycles (2 us at 50 MHz).
- DIR_SETUP_CYC, 50, cycles from DIR/MS valid to the first STEP rise.
- START_PERIOD, 50000, STEP period at the start and end of the ramp, in cycles.
- MIN_PERIOD, 50000/20 = 2500, cruise STEP period in cycles. Must be greater than PULSE_HIGH_CYC.
- ACCEL_DEC, 2500, period change per step during the ramp, in cycles.
- STEP_W, 16, width of the step counters.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle move request; honoured only in IDLE.
- stop  in  1  abort request; level or pulse.
- direcc  in  1  direction, sampled on an accepted start.
- secuenciaPasos  in  3  step mode: 0 full, 1 half, 2 quarter, 3 eighth, 4..7 sixteenth.
- steps_target  in  STEP_W  number of steps, sampled on start.
- STEP  out  1  A4988 STEP pin.
- dirPin  out  1  A4988 DIR pin.
- microStepping  out  3  {MS3,MS2,MS1}.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at move end.
- aborted  out  1  set with done if the move was stopped; cleared on the next start.
- steps_done  out  STEP_W  steps issued in the current or last move.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; STEP=0, dirPin=0, microStepping=000, busy=0, done=0, aborted=0, steps_done=0.
  - Reset mid-pulse drops STEP low immediately.
- MS mapping (A4988 table):
  - 0 -> 000, 1 -> 001, 2 -> 010, 3 -> 011, 4..7 -> 111.
  - Latched on start and held constant for the whole move, including after done.
- FSM states: IDLE, SETUP, PULSE_HI, PULSE_LO, FINISH.
- IDLE:
  - start=1 and stop=0: latch direcc, MS, target; clear steps_done and aborted; go to SETUP next cycle.
  - busy and dirPin/microStepping become valid in the cycle after start.
  - start with stop=1: ignored. stop wins.
  - start with steps_target=0: go to FINISH directly; no STEP.
- SETUP: wait DIR_SETUP_CYC cycles, then go to PULSE_HI. The first STEP rise occurs 1+DIR_SETUP_CYC cycles after start.
- PULSE_HI: STEP=1 for exactly PULSE_HIGH_CYC cycles, then go to PULSE_LO. steps_done increments on entry to PULSE_LO.
- PULSE_LO: STEP=0 for cur_period-PULSE_HIGH_CYC cycles. At the end:
  - If steps_done==target, go to FINISH.
  - Otherwise update cur_period and go to PULSE_HI.
- Ramp update:
  - rem = target - steps_done.
  - If rem <= accel_cnt (decelerating): cur_period = min(cur_period+ACCEL_DEC, START_PERIOD).
  - Else if cur_period > MIN_PERIOD: cur_period = max(cur_period-ACCEL_DEC, MIN_PERIOD) and accel_cnt++.
  - Else: cruise, no change.
  - cur_period=START_PERIOD and accel_cnt=0 at each start.
- stop while busy:
  - In SETUP or PULSE_LO: go to FINISH next cycle.
  - In PULSE_HI: complete the high time (no runt pulse), count the step, then go to FINISH.
  - aborted=1 in both cases.
- FINISH: done=1 for one cycle, busy=0 in the same cycle, then IDLE. start in FINISH is ignored.
- steps_done saturates at target and never wraps.

Optional Feature:
- Macro STEP_POSITION_EN.
- When defined:
  - Adds output position (32-bit signed), cleared only by reset.
  - Each counted step adds +1 if the latched dir=1, else -1.
  - Wraps modulo 2^32.
- When undefined: the port and register do not exist. All other behaviour is identical.

Test Plan:
Bench params: PULSE_HIGH_CYC=4, DIR_SETUP_CYC=3, START_PERIOD=20, MIN_PERIOD=10, ACCEL_DEC=5.
- start at cycle 0, target=1, direcc=1, secuenciaPasos=3 -> dirPin=1 and microStepping=011 from cycle 1; STEP high cycles 4-7, low 16 cycles; done at cycle 24; steps_done=1; aborted=0.
- target=6 -> STEP periods 20,15,10,10,15,20 cycles, each with a 4-cycle high time; six rises total; one done pulse.
- target=0 -> no STEP edge; done pulse 2 cycles after start; steps_done=0.
- target=10, stop asserted 2 cycles into the 3rd high pulse -> that pulse still lasts 4 cycles; steps_done=3; done and aborted=1 together.
- rst low mid-PULSE_HI -> STEP=0 and busy=0 with no clock edge; start with stop=1 in IDLE -> no move.
- STEP_POSITION_EN defined: a 5-step move with dir=1, then a 7-step move with dir=0 -> position=-2.

Source files
------------

// File: rtl/stepper_move_sequencer.sv
// Counted, trapezoidally ramped STEP/DIR/MS sequencer for an A4988 driver.
// Optional macro STEP_POSITION_EN adds a signed 32-bit absolute position output.
module stepper_move_sequencer #(
   parameter int unsigned PULSE_HIGH_CYC = 100,
   parameter int unsigned DIR_SETUP_CYC  = 50,
   parameter int unsigned START_PERIOD   = 50000,
   parameter int unsigned MIN_PERIOD     = 2500,
   parameter int unsigned ACCEL_DEC      = 2500,
   parameter int unsigned STEP_W         = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              direcc,
   input  logic [2:0]        secuenciaPasos,
   input  logic [STEP_W-1:0] steps_target,
   output logic              STEP,
   output logic              dirPin,
   output logic [2:0]        microStepping,
   output logic              busy,
   output logic              done,
   output logic              aborted,
`ifdef STEP_POSITION_EN
   output logic signed [31:0] position,
`endif
   output logic [STEP_W-1:0] steps_done
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SETUP    = 3'd1,
      PULSE_HI = 3'd2,
      PULSE_LO = 3'd3,
      FINISH   = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       cnt_q, cnt_d;
   logic [31:0]       per_q, per_d;
   logic [STEP_W-1:0] accel_q, accel_d;
   logic [STEP_W-1:0] target_q, target_d;
   logic [STEP_W-1:0] steps_q, steps_d;
   logic [STEP_W-1:0] rem;
   logic              dir_q, dir_d;
   logic [2:0]        ms_q, ms_d;
   logic              aborted_q, aborted_d;
   logic              stop_pend_q, stop_pend_d;
   logic              step_q, step_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              count_step;
`ifdef STEP_POSITION_EN
   logic signed [31:0] pos_q, pos_d;
`endif

   function automatic logic [2:0] ms_map(input logic [2:0] mode);
      case (mode)
         3'd0:    ms_map = 3'b000;
         3'd1:    ms_map = 3'b001;
         3'd2:    ms_map = 3'b010;
         3'd3:    ms_map = 3'b011;
         default: ms_map = 3'b111;
      endcase
   endfunction

   function automatic logic [31:0] period_up(input logic [31:0] p);
      period_up = (p + ACCEL_DEC > START_PERIOD) ? START_PERIOD : p + ACCEL_DEC;
   endfunction

   function automatic logic [31:0] period_down(input logic [31:0] p);
      period_down = (p >= MIN_PERIOD + ACCEL_DEC) ? p - ACCEL_DEC : MIN_PERIOD;
   endfunction

   assign rem = target_q - steps_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      per_d       = per_q;
      accel_d     = accel_q;
      target_d    = target_q;
      steps_d     = steps_q;
      dir_d       = dir_q;
      ms_d        = ms_q;
      aborted_d   = aborted_q;
      stop_pend_d = stop_pend_q;
      count_step  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_d     = SETUP;
               dir_d       = direcc;
               ms_d        = ms_map(secuenciaPasos);
               target_d    = steps_target;
               steps_d     = '0;
               aborted_d   = 1'b0;
               per_d       = START_PERIOD;
               accel_d     = '0;
               cnt_d       = '0;
               stop_pend_d = 1'b0;
            end
         end
         // A zero-length move still passes through one SETUP cycle before FINISH.
         SETUP: begin
            if (stop) begin
               state_d   = FINISH;
               aborted_d = 1'b1;
            end else if (target_q == '0) begin
               state_d = FINISH;
            end else if (cnt_q == DIR_SETUP_CYC - 1) begin
               state_d = PULSE_HI;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         // A stop here is remembered so the pulse is never cut short.
         PULSE_HI: begin
            if (stop) stop_pend_d = 1'b1;
            if (cnt_q == PULSE_HIGH_CYC - 1) begin
               cnt_d      = '0;
               count_step = 1'b1;
               if (stop || stop_pend_q) begin
                  state_d   = FINISH;
                  aborted_d = 1'b1;
               end else begin
                  state_d = PULSE_LO;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         PULSE_LO: begin
            if (stop) begin
               state_d   = FINISH;
               aborted_d = 1'b1;
            end else if (cnt_q == per_q - PULSE_HIGH_CYC - 1) begin
               cnt_d = '0;
               if (steps_q == target_q) begin
                  state_d = FINISH;
               end else begin
                  state_d = PULSE_HI;
                  if (rem <= accel_q) begin
                     per_d = period_up(per_q);
                  end else if (per_q > MIN_PERIOD) begin
                     per_d   = period_down(per_q);
                     accel_d = accel_q + STEP_W'(1);
                  end
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (count_step && steps_q != target_q) steps_d = steps_q + STEP_W'(1);

      step_d = (state_d == PULSE_HI);
      busy_d = (state_d == SETUP) || (state_d == PULSE_HI) || (state_d == PULSE_LO);
      done_d = (state_d == FINISH);
   end

`ifdef STEP_POSITION_EN
   always_comb begin
      pos_d = pos_q;
      if (count_step && steps_q != target_q) pos_d = dir_q ? pos_q + 32'sd1 : pos_q - 32'sd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pos_q <= '0;
      else      pos_q <= pos_d;
   end

   assign position = pos_q;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         per_q       <= START_PERIOD;
         accel_q     <= '0;
         target_q    <= '0;
         steps_q     <= '0;
         dir_q       <= 1'b0;
         ms_q        <= 3'b000;
         aborted_q   <= 1'b0;
         stop_pend_q <= 1'b0;
         step_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         per_q       <= per_d;
         accel_q     <= accel_d;
         target_q    <= target_d;
         steps_q     <= steps_d;
         dir_q       <= dir_d;
         ms_q        <= ms_d;
         aborted_q   <= aborted_d;
         stop_pend_q <= stop_pend_d;
         step_q      <= step_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign STEP          = step_q;
   assign dirPin        = dir_q;
   assign microStepping = ms_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign aborted       = aborted_q;
   assign steps_done    = steps_q;

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Directed bench for stepper_move_sequencer with shortened timing parameters.
module tb_stepper_move_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        direcc = 1'b0;
   logic [2:0]  secuenciaPasos = 3'd0;
   logic [15:0] steps_target = 16'd0;
   logic        STEP, dirPin, busy, done, aborted;
   logic [2:0]  microStepping;
   logic [15:0] steps_done;
`ifdef STEP_POSITION_EN
   logic signed [31:0] position;
`endif

   stepper_move_sequencer #(
      .PULSE_HIGH_CYC(4), .DIR_SETUP_CYC(3), .START_PERIOD(20),
      .MIN_PERIOD(10), .ACCEL_DEC(5), .STEP_W(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .direcc(direcc),
      .secuenciaPasos(secuenciaPasos), .steps_target(steps_target),
      .STEP(STEP), .dirPin(dirPin), .microStepping(microStepping),
      .busy(busy), .done(done), .aborted(aborted),
`ifdef STEP_POSITION_EN
      .position(position),
`endif
      .steps_done(steps_done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic step_hist [0:127];
   int   rises[$];
   int   highs[$];
   int   done_cyc, done_cnt;
   logic dir_c1, busy_c1, ab_done, busy_done;
   logic [2:0]  ms_c1;
   logic [15:0] sd_done;

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Cycle 0 is the cycle in which start is high; cycle c is sampled at the falling edge after c rising edges.
   task automatic run_move(input int tgt, input logic d, input logic [2:0] mode,
                           input int stop_cyc, input int budget);
      steps_target   = 16'(tgt);
      direcc         = d;
      secuenciaPasos = mode;
      start          = 1'b1;
      stop           = 1'b0;
      done_cyc       = -1;
      done_cnt       = 0;
      sd_done        = '1;
      ab_done        = 1'bx;
      busy_done      = 1'bx;
      step_hist[0]   = 1'b0;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         start        = 1'b0;
         step_hist[c] = STEP;
         if (c == 1) begin
            dir_c1  = dirPin;
            ms_c1   = microStepping;
            busy_c1 = busy;
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc  = c;
               sd_done   = steps_done;
               ab_done   = aborted;
               busy_done = busy;
            end
         end
         stop = (c == stop_cyc);
      end
      stop = 1'b0;
      rises.delete();
      highs.delete();
      for (int c = 1; c <= budget; c++)
         if (step_hist[c] && !step_hist[c-1]) rises.push_back(c);
      for (int i = 0; i < rises.size(); i++) begin
         int n = 0;
         int c = rises[i];
         while (c <= budget && step_hist[c]) begin
            n++;
            c++;
         end
         highs.push_back(n);
      end
   endtask

   function automatic int rise_at(input int i);
      rise_at = (i < rises.size()) ? rises[i] : -1;
   endfunction

   function automatic int high_at(input int i);
      high_at = (i < highs.size()) ? highs[i] : -1;
   endfunction

   initial begin
      int exp_per[6];
      int per;
      logic any_step, any_busy;
      exp_per = '{20, 15, 10, 10, 15, 20};

      repeat (2) @(negedge clk);
      chk("rst_step", STEP, 0);
      chk("rst_dir", dirPin, 0);
      chk("rst_ms", microStepping, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_aborted", aborted, 0);
      chk("rst_steps_done", steps_done, 0);
      rst = 1'b1;
      @(negedge clk);

      // Single step, eighth-step mode.
      run_move(1, 1'b1, 3'd3, -1, 30);
      chk("t1_dir_c1", dir_c1, 1);
      chk("t1_ms_c1", ms_c1, 3'b011);
      chk("t1_busy_c1", busy_c1, 1);
      chk("t1_nrise", rises.size(), 1);
      chk("t1_rise0", rise_at(0), 4);
      chk("t1_high0", high_at(0), 4);
      chk("t1_done_cyc", done_cyc, 24);
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_steps_done", sd_done, 1);
      chk("t1_aborted", ab_done, 0);
      chk("t1_busy_at_done", busy_done, 0);
      chk("t1_ms_held", microStepping, 3'b011);

      // Six steps: full ramp up, one cruise step, ramp down.
      run_move(6, 1'b0, 3'd5, -1, 100);
      chk("t2_dir_c1", dir_c1, 0);
      chk("t2_ms_c1", ms_c1, 3'b111);
      chk("t2_nrise", rises.size(), 6);
      chk("t2_rise0", rise_at(0), 4);
      for (int i = 0; i < 6; i++) begin
         per = (i < 5) ? rise_at(i + 1) - rise_at(i) : done_cyc - rise_at(i);
         chk($sformatf("t2_period%0d", i), per, exp_per[i]);
         chk($sformatf("t2_high%0d", i), high_at(i), 4);
      end
      chk("t2_done_cyc", done_cyc, 94);
      chk("t2_done_cnt", done_cnt, 1);
      chk("t2_steps_done", sd_done, 6);

      // Zero-step move.
      run_move(0, 1'b1, 3'd2, -1, 8);
      chk("t3_ms_c1", ms_c1, 3'b010);
      chk("t3_nrise", rises.size(), 0);
      chk("t3_done_cyc", done_cyc, 2);
      chk("t3_done_cnt", done_cnt, 1);
      chk("t3_steps_done", sd_done, 0);

      // Stop two cycles into the third pulse (pulse spans cycles 39..42).
      run_move(10, 1'b1, 3'd1, 41, 50);
      chk("t4_ms_c1", ms_c1, 3'b001);
      chk("t4_nrise", rises.size(), 3);
      chk("t4_rise2", rise_at(2), 39);
      chk("t4_high2", high_at(2), 4);
      chk("t4_done_cyc", done_cyc, 43);
      chk("t4_done_cnt", done_cnt, 1);
      chk("t4_steps_done", sd_done, 3);
      chk("t4_aborted", ab_done, 1);

      // start together with stop in IDLE is ignored.
      steps_target = 16'd2;
      start = 1'b1;
      stop  = 1'b1;
      any_step = 1'b0;
      any_busy = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         start = 1'b0;
         stop  = 1'b0;
         any_step = any_step | STEP;
         any_busy = any_busy | busy | done;
      end
      chk("t5_no_step", any_step, 0);
      chk("t5_no_busy", any_busy, 0);
      chk("t5_aborted_kept", aborted, 1);

      // Asynchronous reset in the middle of the first high pulse.
      steps_target = 16'd3;
      direcc = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t6_aborted_cleared", aborted, 0);
      repeat (4) @(negedge clk);
      chk("t6_step_before", STEP, 1);
      #1 rst = 1'b0;
      #1;
      chk("t6_step_async", STEP, 0);
      chk("t6_busy_async", busy, 0);
      chk("t6_dir_async", dirPin, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

`ifdef STEP_POSITION_EN
      run_move(5, 1'b1, 3'd0, -1, 90);
      chk("t7_nrise5", rises.size(), 5);
      chk("t7_pos_fwd", position, 5);
      run_move(7, 1'b0, 3'd0, -1, 110);
      chk("t7_nrise7", rises.size(), 7);
      chk("t7_pos_net", position, -2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
